// File: rtl/mig7_mem_tester.sv
// mig7_mem_tester: DDR3 pattern tester that drives the MIG7 user (app_*)
// interface directly.
//
// After a start pulse it waits for calibration. It writes the pattern
// {i, ~i, i^SEED, ~(i^SEED)} to ADDR_BASE + 8*i for i = 0..NUM_WORDS-1.
// It then reads the window back and checks the data in order.
//
// Ports:
//   clk, rst                 MIG ui_clk, synchronous active-high reset
//   start, continuous        run request (IDLE only); repeat passes while 1
//   init_calib_complete      MIG calibration done
//   app_*                    MIG user interface (command, write data, read data)
//   busy                     run in progress
//   done                     sticky pass/run finished
//   error                    sticky mismatch or watchdog expiry
//   timeout                  sticky watchdog expiry
//   err_cnt                  mismatching words (saturating)
//   first_err_addr           app_addr of the first mismatching word
//   loop_cnt                 completed passes (wraps)
//   dbg_state                current FSM state
//
// Handshakes: a command transfers on a cycle with app_en & app_rdy. A write
// beat transfers on a cycle with app_wdf_wren & app_wdf_rdy. A read beat
// arrives on a cycle with app_rd_data_valid (there is no back-pressure).
// While valid is high, the payload is held stable until it is accepted.
module mig7_mem_tester #(
   parameter logic [27:0] ADDR_BASE = 28'd0,
   parameter int unsigned NUM_WORDS = 1024,
   parameter logic [31:0] SEED      = 32'hA5A5_0F0F,
   parameter int unsigned TIMEOUT   = 65535
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         continuous,
   input  logic         init_calib_complete,
   output logic [27:0]  app_addr,
   output logic [2:0]   app_cmd,
   output logic         app_en,
   input  logic         app_rdy,
   output logic [127:0] app_wdf_data,
   output logic         app_wdf_end,
   output logic [15:0]  app_wdf_mask,
   output logic         app_wdf_wren,
   input  logic         app_wdf_rdy,
   input  logic [127:0] app_rd_data,
   input  logic         app_rd_data_end,
   input  logic         app_rd_data_valid,
   output logic         app_sr_req,
   output logic         app_ref_req,
   output logic         app_zq_req,
   input  logic         app_sr_active,
   input  logic         app_ref_ack,
   input  logic         app_zq_ack,
   output logic         busy,
   output logic         done,
   output logic         error,
   output logic         timeout,
   output logic [31:0]  err_cnt,
   output logic [27:0]  first_err_addr,
   output logic [31:0]  loop_cnt,
   output logic [2:0]   dbg_state
);
   typedef enum logic [2:0] {S_IDLE, S_WAIT_CAL, S_WRITE, S_READ, S_DONE} state_t;

   localparam logic [31:0] NW       = 32'(NUM_WORDS);
   localparam logic [31:0] LAST_IDX = 32'(NUM_WORDS - 1);
   localparam logic [31:0] TO_LIM   = 32'(TIMEOUT);

   state_t        state_q, state_d;
   logic [31:0]   wr_idx_q, wr_idx_d;
   logic [31:0]   rd_cmd_idx_q, rd_cmd_idx_d;
   logic [31:0]   rd_chk_idx_q, rd_chk_idx_d;
   logic [31:0]   wd_cnt_q, wd_cnt_d;
   logic          cmd_done_q, cmd_done_d;
   logic          dat_done_q, dat_done_d;
   logic          done_q, done_d;
   logic          error_q, error_d;
   logic          timeout_q, timeout_d;
   logic [31:0]   err_cnt_q, err_cnt_d;
   logic [27:0]   first_err_addr_q, first_err_addr_d;
   logic [31:0]   loop_cnt_q, loop_cnt_d;

   logic          in_write, in_read, rd_issuing;
   logic          cmd_acc, dat_acc, rd_hit, mismatch, progress;
   logic          cmd_ok, dat_ok;
   logic [24:0]   cur_idx;

   function automatic logic [127:0] pattern(input logic [31:0] i);
      return {i, ~i, i ^ SEED, ~(i ^ SEED)};
   endfunction

   // These MIG status inputs are not needed by the tester.
   logic unused_inputs;
   assign unused_inputs = &{1'b0, app_rd_data_end, app_sr_active, app_ref_ack, app_zq_ack};

   assign in_write   = (state_q == S_WRITE);
   assign in_read    = (state_q == S_READ);
   assign rd_issuing = in_read && (rd_cmd_idx_q < NW);

   assign app_en       = (in_write && !cmd_done_q) || rd_issuing;
   assign app_cmd      = in_read ? 3'b001 : 3'b000;
   assign cur_idx      = in_read ? rd_cmd_idx_q[24:0] : wr_idx_q[24:0];
   assign app_addr     = app_en ? ADDR_BASE + {cur_idx, 3'b000} : 28'd0;
   assign app_wdf_wren = in_write && !dat_done_q;
   assign app_wdf_end  = app_wdf_wren;
   assign app_wdf_data = app_wdf_wren ? pattern(wr_idx_q) : 128'd0;
   assign app_wdf_mask = 16'd0;
   assign app_sr_req   = 1'b0;
   assign app_ref_req  = 1'b0;
   assign app_zq_req   = 1'b0;

   assign cmd_acc  = app_en && app_rdy;
   assign dat_acc  = app_wdf_wren && app_wdf_rdy;
   assign rd_hit   = in_read && app_rd_data_valid;
   assign mismatch = rd_hit && (app_rd_data != pattern(rd_chk_idx_q));
   assign progress = cmd_acc || dat_acc || rd_hit;
   // The command and data sides of a write each complete on their own.
   // The write index moves on only once both are complete.
   assign cmd_ok   = cmd_done_q || cmd_acc;
   assign dat_ok   = dat_done_q || dat_acc;

   assign busy           = (state_q == S_WAIT_CAL) || in_write || in_read;
   assign done           = done_q;
   assign error          = error_q;
   assign timeout        = timeout_q;
   assign err_cnt        = err_cnt_q;
   assign first_err_addr = first_err_addr_q;
   assign loop_cnt       = loop_cnt_q;
   assign dbg_state      = state_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= S_IDLE;
         wr_idx_q         <= '0;
         rd_cmd_idx_q     <= '0;
         rd_chk_idx_q     <= '0;
         wd_cnt_q         <= '0;
         cmd_done_q       <= 1'b0;
         dat_done_q       <= 1'b0;
         done_q           <= 1'b0;
         error_q          <= 1'b0;
         timeout_q        <= 1'b0;
         err_cnt_q        <= '0;
         first_err_addr_q <= '0;
         loop_cnt_q       <= '0;
      end else begin
         state_q          <= state_d;
         wr_idx_q         <= wr_idx_d;
         rd_cmd_idx_q     <= rd_cmd_idx_d;
         rd_chk_idx_q     <= rd_chk_idx_d;
         wd_cnt_q         <= wd_cnt_d;
         cmd_done_q       <= cmd_done_d;
         dat_done_q       <= dat_done_d;
         done_q           <= done_d;
         error_q          <= error_d;
         timeout_q        <= timeout_d;
         err_cnt_q        <= err_cnt_d;
         first_err_addr_q <= first_err_addr_d;
         loop_cnt_q       <= loop_cnt_d;
      end
   end

   always_comb begin
      state_d          = state_q;
      wr_idx_d         = wr_idx_q;
      rd_cmd_idx_d     = rd_cmd_idx_q;
      rd_chk_idx_d     = rd_chk_idx_q;
      cmd_done_d       = cmd_done_q;
      dat_done_d       = dat_done_q;
      done_d           = done_q;
      error_d          = error_q;
      timeout_d        = timeout_q;
      err_cnt_d        = err_cnt_q;
      first_err_addr_d = first_err_addr_q;
      loop_cnt_d       = loop_cnt_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               done_d           = 1'b0;
               error_d          = 1'b0;
               timeout_d        = 1'b0;
               err_cnt_d        = '0;
               first_err_addr_d = '0;
               loop_cnt_d       = '0;
               state_d          = S_WAIT_CAL;
            end
         end
         S_WAIT_CAL: begin
            wr_idx_d     = '0;
            rd_cmd_idx_d = '0;
            rd_chk_idx_d = '0;
            cmd_done_d   = 1'b0;
            dat_done_d   = 1'b0;
            if (init_calib_complete) state_d = S_WRITE;
         end
         S_WRITE: begin
            if (cmd_ok && dat_ok) begin
               cmd_done_d = 1'b0;
               dat_done_d = 1'b0;
               if (wr_idx_q == LAST_IDX) begin
                  wr_idx_d     = '0;
                  rd_cmd_idx_d = '0;
                  rd_chk_idx_d = '0;
                  state_d      = S_READ;
               end else begin
                  wr_idx_d = wr_idx_q + 32'd1;
               end
            end else begin
               cmd_done_d = cmd_ok;
               dat_done_d = dat_ok;
            end
         end
         S_READ: begin
            if (cmd_acc) rd_cmd_idx_d = rd_cmd_idx_q + 32'd1;
            if (rd_hit) begin
               rd_chk_idx_d = rd_chk_idx_q + 32'd1;
               if (mismatch) begin
                  error_d   = 1'b1;
                  err_cnt_d = (err_cnt_q == 32'hFFFF_FFFF) ? err_cnt_q : err_cnt_q + 32'd1;
                  if (err_cnt_q == 32'd0)
                     first_err_addr_d = ADDR_BASE + {rd_chk_idx_q[24:0], 3'b000};
               end
               if (rd_chk_idx_q == LAST_IDX) begin
                  loop_cnt_d = loop_cnt_q + 32'd1;
                  if (continuous) begin
                     wr_idx_d     = '0;
                     rd_cmd_idx_d = '0;
                     rd_chk_idx_d = '0;
                     cmd_done_d   = 1'b0;
                     dat_done_d   = 1'b0;
                     state_d      = S_WRITE;
                  end else begin
                     done_d  = 1'b1;
                     state_d = S_DONE;
                  end
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Progress watchdog: any transfer on any channel restarts the count.
      if ((in_write || in_read) && !progress) wd_cnt_d = wd_cnt_q + 32'd1;
      else                                    wd_cnt_d = '0;

      if ((in_write || in_read) && (wd_cnt_d == TO_LIM)) begin
         timeout_d = 1'b1;
         error_d   = 1'b1;
         done_d    = 1'b1;
         state_d   = S_DONE;
      end
   end
endmodule

// File: tb/tb_mig7_mem_tester.sv
// Directed bench for mig7_mem_tester (NUM_WORDS=4, TIMEOUT=50, ADDR_BASE=0)
// with a small MIG memory model that has a read latency of about 10 cycles.
module tb_mig7_mem_tester;
   localparam int RL = 10;

   logic         clk = 1'b0;
   logic         rst, start, continuous, init_calib_complete;
   logic [27:0]  app_addr;
   logic [2:0]   app_cmd;
   logic         app_en, app_rdy;
   logic [127:0] app_wdf_data;
   logic         app_wdf_end, app_wdf_wren, app_wdf_rdy;
   logic [15:0]  app_wdf_mask;
   logic [127:0] app_rd_data;
   logic         app_rd_data_valid = 1'b0;
   logic         app_rd_data_end, app_sr_active, app_ref_ack, app_zq_ack;
   logic         app_sr_req, app_ref_req, app_zq_req;
   logic         busy, done, error, timeout;
   logic [31:0]  err_cnt, loop_cnt;
   logic [27:0]  first_err_addr;
   logic [2:0]   dbg_state;

   always #5 clk = ~clk;

   mig7_mem_tester #(.ADDR_BASE(28'd0), .NUM_WORDS(4), .SEED(32'hA5A5_0F0F), .TIMEOUT(50)) dut (
      .clk(clk), .rst(rst), .start(start), .continuous(continuous),
      .init_calib_complete(init_calib_complete),
      .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
      .app_wdf_data(app_wdf_data), .app_wdf_end(app_wdf_end), .app_wdf_mask(app_wdf_mask),
      .app_wdf_wren(app_wdf_wren), .app_wdf_rdy(app_wdf_rdy),
      .app_rd_data(app_rd_data), .app_rd_data_end(app_rd_data_end),
      .app_rd_data_valid(app_rd_data_valid),
      .app_sr_req(app_sr_req), .app_ref_req(app_ref_req), .app_zq_req(app_zq_req),
      .app_sr_active(app_sr_active), .app_ref_ack(app_ref_ack), .app_zq_ack(app_zq_ack),
      .busy(busy), .done(done), .error(error), .timeout(timeout),
      .err_cnt(err_cnt), .first_err_addr(first_err_addr), .loop_cnt(loop_cnt),
      .dbg_state(dbg_state)
   );

   // ---------------- scoreboard / checker ----------------
   int checks = 0;
   int errors = 0;
   logic [127:0] exp_q[$];

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Hand-computed patterns for i = 0..3 with SEED = A5A50F0F.
   task automatic load_exp();
      exp_q.delete();
      exp_q.push_back(128'h00000000_FFFFFFFF_A5A50F0F_5A5AF0F0);
      exp_q.push_back(128'h00000001_FFFFFFFE_A5A50F0E_5A5AF0F1);
      exp_q.push_back(128'h00000002_FFFFFFFD_A5A50F0D_5A5AF0F2);
      exp_q.push_back(128'h00000003_FFFFFFFC_A5A50F0C_5A5AF0F3);
   endtask

   // ---------------- MIG memory model ----------------
   logic [127:0] mem [64];
   logic [27:0]  wa_q[$];
   logic [127:0] wdat_q[$];
   int           n_wcmd = 0;
   int           n_rcmd = 0;
   logic         corrupt_en = 1'b0;
   logic         mem_clr = 1'b0;
   logic [RL-1:0] rv_pipe = '0;
   logic [127:0] rd_pipe [RL];

   always @(posedge clk) begin
      logic [127:0] rdata;
      logic [27:0]  wa;
      logic         rnew;
      rnew  = 1'b0;
      rdata = '0;
      if (mem_clr) begin
         for (int i = 0; i < 64; i++) mem[i] = '0;
         wa_q.delete();
         wdat_q.delete();
      end
      if (app_en && app_rdy) begin
         if (app_cmd == 3'b000) begin
            wa_q.push_back(app_addr);
            n_wcmd++;
         end else begin
            rnew  = 1'b1;
            rdata = mem[app_addr[8:3]];
            if (corrupt_en && app_addr == 28'd16) rdata[5] = ~rdata[5];
            n_rcmd++;
         end
      end
      if (app_wdf_wren && app_wdf_rdy) wdat_q.push_back(app_wdf_data);
      while (wa_q.size() > 0 && wdat_q.size() > 0) begin
         wa = wa_q.pop_front();
         mem[wa[8:3]] = wdat_q.pop_front();
      end
      app_rd_data_valid <= rv_pipe[RL-1];
      app_rd_data       <= rd_pipe[RL-1];
      for (int i = RL - 1; i > 0; i--) begin
         rv_pipe[i] = rv_pipe[i-1];
         rd_pipe[i] = rd_pipe[i-1];
      end
      rv_pipe[0] = rnew;
      rd_pipe[0] = rdata;
   end

   // ---------------- driver tasks ----------------
   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic pulse_clr();
      @(negedge clk); mem_clr = 1'b1;
      @(negedge clk); mem_clr = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n = 0;
      while (done !== 1'b1 && n < budget) begin @(negedge clk); n++; end
      chk(tag, done, 1'b1);
   endtask

   task automatic wait_app_en(input string tag);
      int n = 0;
      while (app_en !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      chk(tag, app_en, 1'b1);
   endtask

   task automatic check_mem(input string tag);
      load_exp();
      for (int i = 0; i < 4; i++) chk($sformatf("%s_mem%0d", tag, i), mem[i], exp_q.pop_front());
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_flags"}, {busy, done, error, timeout, app_en, app_wdf_wren, app_wdf_end}, 7'd0);
      chk({tag, "_app_cmd"}, app_cmd, 3'd0);
      chk({tag, "_app_addr"}, app_addr, 28'd0);
      chk({tag, "_app_wdf_data"}, app_wdf_data, 128'd0);
      chk({tag, "_consts"}, {app_wdf_mask, app_sr_req, app_ref_req, app_zq_req}, 19'd0);
      chk({tag, "_err_cnt"}, err_cnt, 32'd0);
      chk({tag, "_first_err_addr"}, first_err_addr, 28'd0);
      chk({tag, "_loop_cnt"}, loop_cnt, 32'd0);
      chk({tag, "_state"}, dbg_state, 3'd0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int bad, w0, r0, n;
      rst = 1'b1; start = 1'b0; continuous = 1'b0; init_calib_complete = 1'b0;
      app_rdy = 1'b1; app_wdf_rdy = 1'b1; app_rd_data_end = 1'b0;
      app_sr_active = 1'b0; app_ref_ack = 1'b0; app_zq_ack = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_state("reset");
      rst = 1'b0;

      // Calibration held off 100 cycles, then one ideal pass.
      pulse_start();
      bad = 0;
      repeat (100) begin
         @(negedge clk);
         if (app_en !== 1'b0 || busy !== 1'b1) bad++;
      end
      chk("cal_wait_no_cmd_busy", bad, 0);
      w0 = n_wcmd; r0 = n_rcmd;
      init_calib_complete = 1'b1;
      @(negedge clk);
      chk("first_wr_en", {app_en, app_wdf_wren, app_wdf_end, app_cmd}, 6'b111_000);
      chk("first_wr_addr", app_addr, 28'd0);
      chk("first_wr_data", app_wdf_data, 128'h00000000_FFFFFFFF_A5A50F0F_5A5AF0F0);
      wait_done("t1_done", 300);
      chk("t1_error", error, 1'b0);
      chk("t1_loop_cnt", loop_cnt, 32'd1);
      chk("t1_err_cnt", err_cnt, 32'd0);
      repeat (20) @(negedge clk);
      chk("t1_busy", busy, 1'b0);
      chk("t1_cmd_total", (n_wcmd - w0) + (n_rcmd - r0), 8);
      chk("t1_no_app_en", app_en, 1'b0);
      check_mem("t1");

      // Independent command / data handshakes.
      pulse_clr();
      w0 = n_wcmd;
      app_wdf_rdy = 1'b0;
      pulse_start();
      wait_app_en("hs_first_en");
      chk("hs_wren0", app_wdf_wren, 1'b1);
      @(negedge clk);
      chk("hs_cmd_dropped", {app_en, app_wdf_wren}, 2'b01);
      @(negedge clk);
      @(negedge clk);
      chk("hs_data_stable", app_wdf_data, 128'h00000000_FFFFFFFF_A5A50F0F_5A5AF0F0);
      chk("hs_cmd_once", n_wcmd - w0, 1);
      app_wdf_rdy = 1'b1;
      @(negedge clk);
      chk("hs_idx1_en", {app_en, app_wdf_wren}, 2'b11);
      chk("hs_idx1_addr", app_addr, 28'd8);
      chk("hs_idx1_data", app_wdf_data, 128'h00000001_FFFFFFFE_A5A50F0E_5A5AF0F1);
      app_rdy = 1'b0;
      @(negedge clk);
      chk("hs_data_dropped", {app_en, app_wdf_wren}, 2'b10);
      repeat (2) @(negedge clk);
      chk("hs_addr_held", app_addr, 28'd8);
      chk("hs_wcmd_count", n_wcmd - w0, 1);
      app_rdy = 1'b1;
      @(negedge clk);
      chk("hs_idx2_addr", app_addr, 28'd16);
      wait_done("hs_done", 300);
      chk("hs_error", error, 1'b0);
      check_mem("hs");

      // Corrupted read of index 2.
      corrupt_en = 1'b1;
      pulse_start();
      wait_done("cor_done", 300);
      chk("cor_err_cnt", err_cnt, 32'd1);
      chk("cor_first_addr", first_err_addr, 28'd16);
      chk("cor_flags", {error, timeout}, 2'b10);
      chk("cor_loop_cnt", loop_cnt, 32'd1);
      corrupt_en = 1'b0;

      // Watchdog: command channel stuck.
      app_rdy = 1'b0;
      pulse_start();
      wait_app_en("to_first_en");
      n = 0;
      while (timeout !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      chk("to_cycles", n, 51);
      chk("to_flags", {timeout, error, done}, 3'b111);
      chk("to_loop_cnt", loop_cnt, 32'd0);
      @(negedge clk);
      chk("to_busy", busy, 1'b0);
      app_rdy = 1'b1;
      pulse_clr();

      // Continuous passes, then reset in the middle of a read phase.
      continuous = 1'b1;
      pulse_start();
      n = 0;
      while (loop_cnt < 32'd3 && n < 1000) begin @(negedge clk); n++; end
      chk("cont_loop3", loop_cnt, 32'd3);
      r0 = n_rcmd;
      n = 0;
      while (n_rcmd == r0 && n < 100) begin @(negedge clk); n++; end
      chk("cont_in_read_busy", {busy, error}, 2'b10);
      rst = 1'b1;
      @(negedge clk);
      check_reset_state("midrst");
      rst = 1'b0;
      continuous = 1'b0;
      repeat (20) @(negedge clk);
      chk("late_err_cnt", err_cnt, 32'd0);
      chk("late_flags", {busy, done, error, timeout}, 4'd0);
      chk("late_loop_cnt", loop_cnt, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL global_time_limit observed running expected finished");
      $fatal(1, "time limit");
   end
endmodule
